// File: rtl/jtag_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_cmd_ctrl
//  Purpose  : Executes debug commands delivered from the JTAG side. Each
//             command updates the address/byte-enable registers, or runs
//             a single-word DMA write/read through the shared buffer. Every
//             command produces exactly one response pulse.
//  Revision : 1.0 - initial release
//
//  Ports
//    clock, reset      system clock; synchronous active-low reset
//    cmd_*             command word in (valid/opcode/data), cmd_ready out
//    rsp_*             response pulse, payload and status out
//    dma_*             transfer request pulses, address, byte enables;
//                      dma_switch_ready in (DMA idle/finished)
//    buf_*             shared one-word buffer port (address fixed at 0)
//
//  Configuration
//    JTAG_CMD_CTRL_TIMEOUT_EN  when defined, each DMA wait phase aborts
//                              after TIMEOUT_CYCLES cycles with status 1.
// ============================================================================
module jtag_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_opcode,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        dma_dataReady,
    output logic        dma_readReady,
    output logic [3:0]  dma_byteEnable,
    output logic [31:0] dma_address,
    input  logic        dma_switch_ready,
    output logic [8:0]  buf_address,
    output logic [31:0] buf_dataIn,
    output logic        buf_writeEnable,
    input  logic [31:0] buf_dataOut
);

    localparam logic [7:0] c_OP_SET_ADDR = 8'h01;
    localparam logic [7:0] c_OP_SET_BE   = 8'h02;
    localparam logic [7:0] c_OP_WRITE    = 8'h03;
    localparam logic [7:0] c_OP_READ     = 8'h04;

    localparam logic [1:0] c_ST_OK      = 2'd0;
    localparam logic [1:0] c_ST_TIMEOUT = 2'd1;
    localparam logic [1:0] c_ST_BAD_OP  = 2'd2;

    // Out-of-range timeout values are rejected at elaboration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
        $error("jtag_cmd_ctrl: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_BUF     = 3'd1,
        S_ISSUE_WR   = 3'd2,
        S_ISSUE_RD   = 3'd3,
        S_WAIT_START = 3'd4,
        S_WAIT_DONE  = 3'd5,
        S_RD_BUF     = 3'd6,
        S_RESP       = 3'd7
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic        r_is_read;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_status;
    logic        r_dma_wr;
    logic        r_dma_rd;
    logic        r_buf_we;
    logic [31:0] r_buf_din;
`ifdef JTAG_CMD_CTRL_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  r_wait_cnt;
`endif

    assign cmd_ready       = (r_state == S_IDLE);
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data        = r_rsp_data;
    assign rsp_status      = r_rsp_status;
    assign dma_dataReady   = r_dma_wr;
    assign dma_readReady   = r_dma_rd;
    assign dma_byteEnable  = r_be;
    assign dma_address     = r_addr;
    assign buf_address     = 9'd0;
    assign buf_dataIn      = r_buf_din;
    assign buf_writeEnable = r_buf_we;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_addr       <= 32'd0;
            r_be         <= 4'd0;
            r_is_read    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 32'd0;
            r_rsp_status <= c_ST_OK;
            r_dma_wr     <= 1'b0;
            r_dma_rd     <= 1'b0;
            r_buf_we     <= 1'b0;
            r_buf_din    <= 32'd0;
`ifdef JTAG_CMD_CTRL_TIMEOUT_EN
            r_wait_cnt   <= 8'd0;
`endif
        end else begin
            // Single-cycle strobes default low.
            r_rsp_valid <= 1'b0;
            r_buf_we    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_opcode)
                            c_OP_SET_ADDR: begin
                                r_addr       <= cmd_data;
                                r_rsp_valid  <= 1'b1;
                                r_rsp_data   <= cmd_data;
                                r_rsp_status <= c_ST_OK;
                                r_state      <= S_RESP;
                            end
                            c_OP_SET_BE: begin
                                r_be         <= cmd_data[3:0];
                                r_rsp_valid  <= 1'b1;
                                r_rsp_data   <= {28'h0, cmd_data[3:0]};
                                r_rsp_status <= c_ST_OK;
                                r_state      <= S_RESP;
                            end
                            c_OP_WRITE: begin
                                r_is_read <= 1'b0;
                                r_buf_we  <= 1'b1;
                                r_buf_din <= cmd_data;
                                r_state   <= S_WR_BUF;
                            end
                            c_OP_READ: begin
                                r_is_read <= 1'b1;
                                r_state   <= S_ISSUE_RD;
                            end
                            default: begin
                                r_rsp_valid  <= 1'b1;
                                r_rsp_data   <= 32'd0;
                                r_rsp_status <= c_ST_BAD_OP;
                                r_state      <= S_RESP;
                            end
                        endcase
                    end
                end

                // Buffer write strobe is high for this one cycle.
                S_WR_BUF: r_state <= S_ISSUE_WR;

                // The request pulse is raised while still in the ISSUE state,
                // so the DMA never sees a request outside ISSUE_WR/ISSUE_RD.
                S_ISSUE_WR: begin
                    if (r_dma_wr) begin
                        r_dma_wr <= 1'b0;
                        r_state  <= S_WAIT_START;
`ifdef JTAG_CMD_CTRL_TIMEOUT_EN
                        r_wait_cnt <= 8'd0;
`endif
                    end else if (dma_switch_ready) begin
                        r_dma_wr <= 1'b1;
                    end
                end

                S_ISSUE_RD: begin
                    if (r_dma_rd) begin
                        r_dma_rd <= 1'b0;
                        r_state  <= S_WAIT_START;
`ifdef JTAG_CMD_CTRL_TIMEOUT_EN
                        r_wait_cnt <= 8'd0;
`endif
                    end else if (dma_switch_ready) begin
                        r_dma_rd <= 1'b1;
                    end
                end

                // DMA acknowledges the request by dropping switch_ready.
                S_WAIT_START: begin
                    if (!dma_switch_ready) begin
                        r_state <= S_WAIT_DONE;
`ifdef JTAG_CMD_CTRL_TIMEOUT_EN
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= {28'h0, r_be};
                        r_rsp_status <= c_ST_TIMEOUT;
                        r_state      <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
                    end
                end

                S_WAIT_DONE: begin
                    if (dma_switch_ready) begin
                        if (r_is_read) begin
                            r_state <= S_RD_BUF;
                        end else begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_data   <= 32'd0;
                            r_rsp_status <= c_ST_OK;
                            r_state      <= S_RESP;
                        end
`ifdef JTAG_CMD_CTRL_TIMEOUT_EN
                    end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= {28'h0, r_be};
                        r_rsp_status <= c_ST_TIMEOUT;
                        r_state      <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
                    end
                end

                // Buffer address is fixed, so the word is valid by the end
                // of this cycle.
                S_RD_BUF: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_data   <= buf_dataOut;
                    r_rsp_status <= c_ST_OK;
                    r_state      <= S_RESP;
                end

                S_RESP:  r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
